// File: rtl/pipeline_debug_controller.sv
// Host-side sequencer for the 5-stage MIPS pipeline: loads instruction memory from
// UART command bytes, runs or single-steps the core, and streams latch snapshots back.
module pipeline_debug_controller #(
    parameter logic [7:0]  CMD_LOAD    = 8'h4C,
    parameter logic [7:0]  CMD_CONT    = 8'h43,
    parameter logic [7:0]  CMD_STEP    = 8'h53,
    parameter logic [31:0] RUN_TIMEOUT = 32'd1_000_000
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_valid,
    input  logic         i_tx_ready,
    input  logic         i_program_end,
    input  logic [63:0]  i_IF_ID_latch,
    input  logic [138:0] i_ID_EX_latch,
    input  logic [75:0]  i_EX_MEM_latch,
    input  logic [70:0]  i_MEM_WB_latch,
    output logic         o_halt,
    output logic         o_write_instruction_flag,
    output logic [31:0]  o_instruction_to_write,
    output logic [31:0]  o_address_to_write_inst,
    output logic         o_busy,
    output logic         o_prog_done
);

    localparam int DUMP_BYTES = 48;
    localparam int SNAP_W     = DUMP_BYTES * 8;
    localparam int TXI_W      = $clog2(DUMP_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_COUNT, S_LD_BYTE, S_LD_WRITE, S_RUN, S_STEP, S_SNAP, S_SEND
    } state_t;

    state_t              r_state, w_next;
    logic [31:0]         r_cycle_cnt;
    logic                r_prog_done;
    logic [8:0]          r_inst_cnt;
    logic [8:0]          r_index;
    logic [1:0]          r_byte_idx;
    logic [TXI_W-1:0]    r_tx_idx;
    logic [TXI_W-1:0]    r_tx_last;
    logic [31:0]         r_word;
    logic [SNAP_W-1:0]   r_shift;

    logic        w_is_load, w_is_cont, w_is_step, w_bad_cmd;
    logic        w_last_write, w_load_ack, w_tx_hs, w_run_end;
    logic [31:0] w_cnt_inc;

    assign w_is_load    = (i_rx_data == CMD_LOAD);
    assign w_is_cont    = (i_rx_data == CMD_CONT);
    assign w_is_step    = (i_rx_data == CMD_STEP);
    assign w_bad_cmd    = (r_state == S_IDLE) && i_rx_valid && !(w_is_load || w_is_cont || w_is_step);
    assign w_last_write = ((r_index + 9'd1) == r_inst_cnt);
    assign w_load_ack   = (r_state == S_LD_WRITE) && w_last_write;
    assign w_tx_hs      = (r_state == S_SEND) && i_tx_ready;
    assign w_cnt_inc    = r_cycle_cnt + 32'd1;
    // Program end and timeout collapse into a single halt event.
    assign w_run_end    = i_program_end || (w_cnt_inc >= RUN_TIMEOUT);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    if (w_is_load)      w_next = S_LD_COUNT;
                    else if (w_is_cont) w_next = r_prog_done ? S_SNAP : S_RUN;
                    else if (w_is_step) w_next = r_prog_done ? S_SNAP : S_STEP;
                    else                w_next = S_SEND;
                end
            end
            S_LD_COUNT: if (i_rx_valid) w_next = S_LD_BYTE;
            S_LD_BYTE:  if (i_rx_valid && (r_byte_idx == 2'd3)) w_next = S_LD_WRITE;
            S_LD_WRITE: w_next = w_last_write ? S_SEND : S_LD_BYTE;
            S_RUN:      if (w_run_end) w_next = S_SNAP;
            S_STEP:     w_next = S_SNAP;
            S_SNAP:     w_next = S_SEND;
            S_SEND:     if (w_tx_hs && (r_tx_idx == r_tx_last)) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_halt                   = 1'b1;
        o_write_instruction_flag = 1'b0;
        o_instruction_to_write   = 32'd0;
        o_address_to_write_inst  = 32'd0;
        o_tx_valid               = 1'b0;
        o_tx_data                = 8'd0;
        o_busy                   = (r_state != S_IDLE);
        case (r_state)
            S_RUN, S_STEP: o_halt = 1'b0;
            S_LD_WRITE: begin
                o_write_instruction_flag = 1'b1;
                o_instruction_to_write   = r_word;
                o_address_to_write_inst  = {21'd0, r_index, 2'b00};
            end
            S_SEND: begin
                o_tx_valid = 1'b1;
                o_tx_data  = r_shift[SNAP_W-1 -: 8];
            end
            default: ;
        endcase
    end

    assign o_prog_done = r_prog_done;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cycle_cnt <= 32'd0;
            r_prog_done <= 1'b0;
            r_inst_cnt  <= 9'd0;
            r_index     <= 9'd0;
            r_byte_idx  <= 2'd0;
            r_tx_idx    <= '0;
            r_tx_last   <= '0;
        end else begin
            case (r_state)
                S_LD_COUNT: begin
                    if (i_rx_valid) begin
                        r_inst_cnt  <= {(i_rx_data == 8'd0), i_rx_data};
                        r_cycle_cnt <= 32'd0;
                        r_prog_done <= 1'b0;
                        r_index     <= 9'd0;
                        r_byte_idx  <= 2'd0;
                    end
                end
                S_LD_BYTE:  if (i_rx_valid) r_byte_idx <= r_byte_idx + 2'd1;
                S_LD_WRITE: r_index <= r_index + 9'd1;
                S_RUN: begin
                    r_cycle_cnt <= w_cnt_inc;
                    if (w_run_end) r_prog_done <= 1'b1;
                end
                S_STEP: begin
                    r_cycle_cnt <= w_cnt_inc;
                    if (i_program_end) r_prog_done <= 1'b1;
                end
                default: ;
            endcase

            if (r_state != S_SEND)  r_tx_idx <= '0;
            else if (w_tx_hs)       r_tx_idx <= r_tx_idx + 1'b1;

            if (r_state == S_SNAP)            r_tx_last <= TXI_W'(DUMP_BYTES - 1);
            else if (w_bad_cmd || w_load_ack) r_tx_last <= '0;
        end
    end

    // Datapath registers carry no reset; outputs are gated by state instead.
    always_ff @(posedge i_clk) begin
        if ((r_state == S_LD_BYTE) && i_rx_valid)
            r_word <= {r_word[23:0], i_rx_data};

        if (r_state == S_SNAP)
            r_shift <= {2'b00, i_IF_ID_latch, i_ID_EX_latch, i_EX_MEM_latch,
                        i_MEM_WB_latch, r_cycle_cnt};
        else if (w_bad_cmd)
            r_shift <= {8'h3F, {(SNAP_W-8){1'b0}}};
        else if (w_load_ack)
            r_shift <= {8'h4B, {(SNAP_W-8){1'b0}}};
        else if (w_tx_hs)
            r_shift <= {r_shift[SNAP_W-9:0], 8'h00};
    end

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Scoreboard bench for pipeline_debug_controller: a command-level model predicts
// transmitted bytes, instruction writes and unhalted-cycle counts.
module tb_pipeline_debug_controller;

    localparam logic [31:0] TO = 32'd16;

    logic         i_clk, i_reset;
    logic [7:0]   i_rx_data;
    logic         i_rx_valid;
    logic [7:0]   o_tx_data;
    logic         o_tx_valid;
    logic         i_tx_ready;
    logic         i_program_end;
    logic [63:0]  i_IF_ID_latch;
    logic [138:0] i_ID_EX_latch;
    logic [75:0]  i_EX_MEM_latch;
    logic [70:0]  i_MEM_WB_latch;
    logic         o_halt, o_write_instruction_flag, o_busy, o_prog_done;
    logic [31:0]  o_instruction_to_write, o_address_to_write_inst;

    pipeline_debug_controller #(.RUN_TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .i_program_end(i_program_end),
        .i_IF_ID_latch(i_IF_ID_latch), .i_ID_EX_latch(i_ID_EX_latch),
        .i_EX_MEM_latch(i_EX_MEM_latch), .i_MEM_WB_latch(i_MEM_WB_latch),
        .o_halt(o_halt), .o_write_instruction_flag(o_write_instruction_flag),
        .o_instruction_to_write(o_instruction_to_write),
        .o_address_to_write_inst(o_address_to_write_inst),
        .o_busy(o_busy), .o_prog_done(o_prog_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  exp_tx[$];
    logic [63:0] exp_wr[$];
    logic [31:0] words[$];

    int unsigned m_cnt  = 0;
    bit          m_done = 0;

    int unhalted_total = 0;
    int pe_abs         = 0;
    int hs_total       = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #900_000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    // Unhalted-cycle counter and program_end driver (asserted on the k-th unhalted cycle).
    initial begin
        i_program_end = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_reset && !o_halt) unhalted_total++;
            i_program_end = !o_halt && (pe_abs != 0) && (unhalted_total == pe_abs);
        end
    end

    // TX ready driver plus TX monitor: a byte is consumed at the posedge after the negedge
    // where valid & ready are both seen.
    initial begin
        int   stall_left = 5;
        bit   prev_stall = 0;
        logic [7:0] prev_data = 8'd0;
        logic [7:0] e;
        i_tx_ready = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                prev_stall = 0;
                i_tx_ready = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("tx_hold_valid", 64'(o_tx_valid), 64'd1);
                    chk("tx_hold_data", 64'(o_tx_data), 64'(prev_data));
                end
                if (!o_tx_valid) i_tx_ready = 1'($urandom_range(0, 1));
                else if (stall_left > 0) begin
                    i_tx_ready = 1'b0;
                    stall_left--;
                end else if ($urandom_range(0, 15) == 0) begin
                    i_tx_ready = 1'b0;
                    stall_left = 4;
                end else i_tx_ready = 1'b1;
                if (o_tx_valid && i_tx_ready) begin
                    if (exp_tx.size() == 0) chk("tx_unexpected", 64'(o_tx_data), 64'hFFFF);
                    else begin
                        e = exp_tx.pop_front();
                        chk("tx_byte", 64'(o_tx_data), 64'(e));
                    end
                    hs_total++;
                end
                prev_stall = o_tx_valid && !i_tx_ready;
                prev_data  = o_tx_data;
            end
        end
    end

    // Instruction write monitor.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge i_clk);
            if (!i_reset && o_write_instruction_flag) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", {o_instruction_to_write, o_address_to_write_inst}, 64'hFFFF);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_word_addr", {o_instruction_to_write, o_address_to_write_inst}, e);
                end
            end
        end
    end

    task automatic rand_latches();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom}; i_IF_ID_latch  = r[63:0];
        r = {$urandom, $urandom, $urandom, $urandom, $urandom}; i_ID_EX_latch  = r[138:0];
        r = {$urandom, $urandom, $urandom, $urandom, $urandom}; i_EX_MEM_latch = r[75:0];
        r = {$urandom, $urandom, $urandom, $urandom, $urandom}; i_MEM_WB_latch = r[70:0];
    endtask

    task automatic push_dump();
        logic [383:0] d;
        d = {2'b00, i_IF_ID_latch, i_ID_EX_latch, i_EX_MEM_latch, i_MEM_WB_latch, m_cnt};
        for (int i = 0; i < 48; i++) exp_tx.push_back(d[383 - 8*i -: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (o_busy && cyc < 20000) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("idle_timeout", 64'(o_busy), 64'd0);
        chk("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
    endtask

    task automatic load_words();
        int base = unhalted_total;
        int n    = words.size();
        for (int i = 0; i < n; i++) exp_wr.push_back({words[i], 32'(i * 4)});
        exp_tx.push_back(8'h4B);
        send_byte(8'h4C);
        send_byte((n == 256) ? 8'd0 : 8'(n));
        for (int i = 0; i < n; i++)
            for (int b = 3; b >= 0; b--) send_byte(words[i][8*b +: 8]);
        wait_idle();
        m_cnt  = 0;
        m_done = 0;
        chk("load_halted", 64'(unhalted_total - base), 64'd0);
        chk("load_writes_done", 64'(exp_wr.size()), 64'd0);
        chk("load_prog_done", 64'(o_prog_done), 64'd0);
    endtask

    task automatic load_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
        load_words();
    endtask

    // k: program_end is raised on the k-th unhalted cycle of this command (0 = never).
    task automatic do_cmd(input logic [7:0] op, input int k);
        int base, exp_unh, n_to, n;
        rand_latches();
        exp_unh = 0;
        if (op == 8'h53) begin
            if (!m_done) begin
                m_cnt++;
                exp_unh = 1;
                if (k == 1) m_done = 1;
            end
            push_dump();
        end else if (op == 8'h43) begin
            if (!m_done) begin
                n_to = (m_cnt + 1 >= TO) ? 1 : int'(TO - m_cnt);
                n = (k != 0 && k <= n_to) ? k : n_to;
                m_cnt += n;
                m_done = 1;
                exp_unh = n;
            end
            push_dump();
        end else begin
            exp_tx.push_back(8'h3F);
        end
        base = unhalted_total;
        pe_abs = (k != 0) ? base + k : 0;
        send_byte(op);
        wait_idle();
        pe_abs = 0;
        chk("unhalted_cycles", 64'(unhalted_total - base), 64'(exp_unh));
        chk("prog_done", 64'(o_prog_done), 64'(m_done));
        chk("halt_idle", 64'(o_halt), 64'd1);
    endtask

    initial begin
        logic [7:0] b;
        int base, cyc;
        i_reset = 1'b1;
        i_rx_data = 8'd0;
        i_rx_valid = 1'b0;
        rand_latches();
        repeat (3) @(negedge i_clk);
        chk("rst_halt", 64'(o_halt), 64'd1);
        chk("rst_tx_valid", 64'(o_tx_valid), 64'd0);
        chk("rst_tx_data", 64'(o_tx_data), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_prog_done", 64'(o_prog_done), 64'd0);
        chk("rst_wr_flag", {o_instruction_to_write, o_address_to_write_inst}, 64'd0);
        chk("rst_wr_strobe", 64'(o_write_instruction_flag), 64'd0);
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);

        words.delete();
        words.push_back(32'h20080005);
        words.push_back(32'h00000000);
        load_words();
        do_cmd(8'h53, 0);

        load_words();
        do_cmd(8'h43, 7);
        chk("cont_count", 64'(m_cnt), 64'd7);
        do_cmd(8'h53, 0);

        load_words();
        do_cmd(8'h43, 0);
        chk("timeout_count", 64'(m_cnt), 64'h10);

        do_cmd(8'h58, 0);
        load_random(256);

        // Reset in the middle of a dump.
        rand_latches();
        m_cnt++;
        push_dump();
        base = hs_total;
        send_byte(8'h53);
        cyc = 0;
        while (hs_total < base + 10 && cyc < 5000) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("midsend_reached", 64'(hs_total >= base + 10), 64'd1);
        @(posedge i_clk);
        #2 i_reset = 1'b1;
        #1;
        chk("midrst_tx_valid", 64'(o_tx_valid), 64'd0);
        chk("midrst_halt", 64'(o_halt), 64'd1);
        chk("midrst_busy", 64'(o_busy), 64'd0);
        exp_tx.delete();
        m_cnt = 0;
        m_done = 0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        do_cmd(8'h53, 0);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 9))
                0: load_random(int'($urandom_range(1, 4)));
                1: begin
                    do b = 8'($urandom); while (b == 8'h4C || b == 8'h43 || b == 8'h53);
                    do_cmd(b, 0);
                end
                2, 3, 4, 5: do_cmd(8'h53, ($urandom_range(0, 3) == 0) ? 1 : 0);
                default: do_cmd(8'h43, int'($urandom_range(0, 20)));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_debug_controller.md
Name: pipeline_debug_controller

Overview:
- Host-facing sequencer for the 5-stage MIPS pipeline.
- Takes command bytes from the UART RX side and loads the program into instruction memory through the pipeline's instruction-write port.
- Runs the pipeline continuously or one cycle at a time by driving its halt input.
- After every run or step, snapshots the four inter-stage latches plus a cycle counter and streams them, MSB first, to the UART TX side over a valid/ready handshake.

Parameters:
CMD_LOAD, 8'h4C, opcode 'L': load program
CMD_CONT, 8'h43, opcode 'C': run continuously until program end
CMD_STEP, 8'h53, opcode 'S': advance exactly one clock
RUN_TIMEOUT, 32'd1_000_000, maximum unhalted cycles in continuous mode before forced halt
DUMP_BYTES, 48, bytes per dump (384 bits)

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_rx_data  input  8  received byte
i_rx_valid  input  1  1-cycle pulse, i_rx_data valid
o_tx_data  output  8  byte to transmit
o_tx_valid  output  1  o_tx_data valid
i_tx_ready  input  1  transmitter accepts byte when o_tx_valid & i_tx_ready
i_program_end  input  1  pipeline decoded end-of-program
i_IF_ID_latch  input  64  pipeline IF/ID contents
i_ID_EX_latch  input  139  pipeline ID/EX contents
i_EX_MEM_latch  input  76  pipeline EX/MEM contents
i_MEM_WB_latch  input  71  pipeline MEM/WB contents
o_halt  output  1  freezes pipeline when 1
o_write_instruction_flag  output  1  1-cycle instruction write strobe
o_instruction_to_write  output  32  instruction word
o_address_to_write_inst  output  32  byte address of instruction
o_busy  output  1  1 when not in IDLE
o_prog_done  output  1  sticky: program end or timeout reached

Behaviour:
- Reset is asynchronous, active-high.
  - Outputs on reset: o_halt=1; all other outputs 0; state IDLE.
  - Cycle counter and prog_done cleared.
  - Reset asserted mid-operation aborts immediately; no partial tx byte is held.
- States: IDLE, LD_COUNT, LD_BYTE, LD_WRITE, RUN, STEP, SNAP, SEND.
- IDLE: accepts a byte on i_rx_valid.
  - CMD_LOAD -> LD_COUNT.
  - CMD_CONT -> RUN, or SNAP if prog_done=1.
  - CMD_STEP -> STEP, or SNAP if prog_done=1.
  - Any other byte -> send the single byte 8'h3F, return to IDLE.
- RX bytes arriving outside IDLE/LD_COUNT/LD_BYTE are dropped.
- LD_COUNT: next byte is N, the instruction count; N=0 means 256.
  - Clears the cycle counter, prog_done and the word index.
- LD_BYTE: shifts 4 bytes MSB first into the instruction word.
  - After the 4th byte -> LD_WRITE.
- LD_WRITE: exactly one cycle.
  - o_write_instruction_flag=1, o_instruction_to_write=word, o_address_to_write_inst=index*4.
  - Index increments. If index reaches N -> send ack byte 8'h4B, then IDLE; otherwise -> LD_BYTE.
  - o_halt stays 1 throughout loading.
- RUN: o_halt=0 and the cycle counter increments every cycle.
  - i_program_end=1 (sampled) -> o_halt=1 on the next edge; prog_done=1; -> SNAP.
  - Counter reaching RUN_TIMEOUT -> same transition; prog_done=1.
  - Program end and timeout in the same cycle is treated as one event.
- STEP: o_halt=0 for exactly one cycle; counter +1; -> SNAP.
  - If i_program_end=1 in that cycle, prog_done=1.
- SNAP: o_halt=1; captures {2'b00, IF_ID, ID_EX, EX_MEM, MEM_WB, cycle_counter} (384 bits) in one cycle.
  - Snapshot latency after the halting edge: 1 cycle.
- SEND: presents the snapshot MSB byte first.
  - Holds o_tx_data/o_tx_valid stable until i_tx_ready.
  - Advances one byte per handshake; after byte DUMP_BYTES-1 handshakes -> IDLE.
  - o_tx_valid never drops before the handshake.
- Counter: 32-bit, wraps silently at 2^32-1.
- o_busy = (state != IDLE). The single-byte responses (3F, 4B) also use SEND with one byte.

Test Plan:
- Reset mid-SEND (byte 10 of 48): o_tx_valid=0 and o_halt=1 immediately; next 'S' produces a full 48-byte dump starting at byte 0.
- 'L', 8'h02, 20 08 00 05, 00 00 00 00 -> two write strobes: (0x20080005, addr 0) then (0x00000000, addr 4); ack 8'h4B; o_halt=1 throughout.
- After load, 'S' -> o_halt low for exactly 1 cycle; 48 bytes sent; last 4 bytes = 00000001; bytes 0..7 reflect IF/ID with PC bits matching the pipeline.
- 'C' with i_program_end asserted at the 7th unhalted cycle -> o_halt rises the following edge; counter bytes = 00000007; o_prog_done=1; subsequent 'S' sends a dump with counter still 7 and no unhalted cycle.
- RUN_TIMEOUT=16 with i_program_end tied 0, 'C' -> forced halt after 16 cycles; counter = 00000010; o_prog_done=1.
- Byte 8'h58 in IDLE -> single response 8'h3F; i_tx_ready held low for 5 cycles during any dump -> o_tx_data stable, no byte skipped or duplicated.
